// File: rtl/layer_sequencer_if.sv
// Bundle of the layer sequencer's control, memory-read and process-unit signals.
// The master side is the sequencer; the slave side is its environment.
interface layer_sequencer_if #(
    parameter int I_WIDTH = 4
);
    logic                   start;
    logic                   abort;
    logic [I_WIDTH:0]       cfg_n;
    logic [I_WIDTH:0]       cfg_m;
    logic [I_WIDTH-1:0]     x_addr;
    logic                   x_rd;
    logic [15:0]            x_data;
    logic [2*I_WIDTH-1:0]   w_addr;
    logic                   w_rd;
    logic [15:0]            w_data;
    logic                   pe_fetch_enable;
    logic [15:0]            pe_a;
    logic [15:0]            pe_b;
    logic [I_WIDTH-1:0]     pe_weight_index;
    logic                   pe_finish_enable;
    logic                   busy;
    logic                   done;
    logic [2:0]             state_dbg;

    // Memories return data the cycle after the strobe; start/abort are sampled on
    // each rising edge, and pe_fetch_enable / pe_finish_enable / done are one-cycle pulses.
    modport master (
        input  start, abort, cfg_n, cfg_m, x_data, w_data,
        output x_addr, x_rd, w_addr, w_rd, pe_fetch_enable, pe_a, pe_b,
               pe_weight_index, pe_finish_enable, busy, done, state_dbg
    );

    modport slave (
        output start, abort, cfg_n, cfg_m, x_data, w_data,
        input  x_addr, x_rd, w_addr, w_rd, pe_fetch_enable, pe_a, pe_b,
               pe_weight_index, pe_finish_enable, busy, done, state_dbg
    );
endinterface

// File: rtl/layer_sequencer.sv
// Walks an N x M fully-connected layer, issuing one MAC every SLOT+1 cycles
// to a process unit, then a finish request and a done pulse.
module layer_sequencer #(
    parameter int I_WIDTH = 4,
    parameter int SLOT    = 5
) (
    input logic               m_clk,
    input logic               rst,
    layer_sequencer_if.master bus
);
    localparam int CW = (SLOT > 2) ? $clog2(SLOT) : 1;
    localparam int KW = 2 * I_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [I_WIDTH:0]   n_q, n_d, m_q, m_d;
    logic [I_WIDTH-1:0] i_q, i_d, j_q, j_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [I_WIDTH-1:0] x_addr_q, x_addr_d;
    logic [KW-1:0]      w_addr_q, w_addr_d;
    logic               rd_q, rd_d;
    logic               fetch_q, fetch_d;
    logic               finish_q, finish_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [15:0]        pe_a_q, pe_a_d, pe_b_q, pe_b_d;
    logic [I_WIDTH-1:0] wi_q, wi_d;
    logic               j_last, i_last;

    assign j_last = ({1'b0, j_q} == m_q - (I_WIDTH+1)'(1));
    assign i_last = ({1'b0, i_q} == n_q - (I_WIDTH+1)'(1));

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        x_addr_d = x_addr_q;
        w_addr_d = w_addr_q;
        rd_d     = 1'b0;
        fetch_d  = 1'b0;
        finish_d = 1'b0;
        done_d   = 1'b0;
        pe_a_d   = pe_a_q;
        pe_b_d   = pe_b_q;
        wi_d     = wi_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    n_d      = bus.cfg_n;
                    m_d      = bus.cfg_m;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    x_addr_d = '0;
                    w_addr_d = '0;
                    state_d  = ST_RD;
                    // An empty layer passes through RD without touching memory.
                    rd_d     = (bus.cfg_n != '0) && (bus.cfg_m != '0);
                end
            end
            ST_RD: begin
                if (n_q == '0 || m_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                    fetch_d = 1'b1;
                    wi_d    = j_q;
                end
            end
            ST_ISSUE: begin
                pe_a_d  = bus.x_data;
                pe_b_d  = bus.w_data;
                cnt_d   = CW'(SLOT - 2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (i_last && j_last) begin
                    state_d  = ST_FIN;
                    finish_d = 1'b1;
                end else begin
                    if (j_last) begin
                        j_d = '0;
                        i_d = i_q + I_WIDTH'(1);
                    end else begin
                        j_d = j_q + I_WIDTH'(1);
                    end
                    k_d      = k_q + KW'(1);
                    x_addr_d = i_d;
                    w_addr_d = k_d;
                    rd_d     = 1'b1;
                    state_d  = ST_RD;
                end
            end
            ST_FIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            rd_d     = 1'b0;
            fetch_d  = 1'b0;
            finish_d = 1'b0;
            done_d   = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge m_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            m_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            x_addr_q <= '0;
            w_addr_q <= '0;
            rd_q     <= 1'b0;
            fetch_q  <= 1'b0;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pe_a_q   <= '0;
            pe_b_q   <= '0;
            wi_q     <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            m_q      <= m_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            x_addr_q <= x_addr_d;
            w_addr_q <= w_addr_d;
            rd_q     <= rd_d;
            fetch_q  <= fetch_d;
            finish_q <= finish_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pe_a_q   <= pe_a_d;
            pe_b_q   <= pe_b_d;
            wi_q     <= wi_d;
        end
    end

    // Read data only arrives in the ISSUE cycle itself, so operands pass straight
    // through then and are held from the captured copy afterwards.
    assign bus.pe_a             = (state_q == ST_ISSUE) ? bus.x_data : pe_a_q;
    assign bus.pe_b             = (state_q == ST_ISSUE) ? bus.w_data : pe_b_q;
    assign bus.pe_weight_index  = wi_q;
    assign bus.pe_fetch_enable  = fetch_q;
    assign bus.pe_finish_enable = finish_q;
    assign bus.x_addr           = x_addr_q;
    assign bus.w_addr           = w_addr_q;
    assign bus.x_rd             = rd_q;
    assign bus.w_rd             = rd_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.state_dbg        = state_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: timing of fetch/finish/done, operand
// tuples, address sequences, zero-size, abort/restart and async reset.
module tb_layer_sequencer;
    logic m_clk = 1'b0;
    logic rst   = 1'b0;
    int   total = 0;
    int   bad   = 0;

    layer_sequencer_if #(.I_WIDTH(4)) bus ();

    layer_sequencer #(.I_WIDTH(4), .SLOT(5)) dut (
        .m_clk (m_clk),
        .rst   (rst),
        .bus   (bus.master)
    );

    always #5 m_clk = ~m_clk;

    // Memory model: x[i] = 2*i+3, W[k] = k+1 (so x=[3,5,..], W=[1..6,..]).
    logic [15:0] xmem [16];
    logic [15:0] wmem [256];
    initial begin
        for (int a = 0; a < 16; a++) xmem[a] = 16'(2 * a + 3);
        for (int a = 0; a < 256; a++) wmem[a] = 16'(a + 1);
    end
    always @(posedge m_clk) begin
        if (bus.x_rd) bus.x_data <= xmem[bus.x_addr];
        if (bus.w_rd) bus.w_data <= wmem[bus.w_addr];
    end

    int          fetch_cyc_q[$];
    logic [15:0] fa_q[$];
    logic [15:0] fb_q[$];
    int          fwi_q[$];
    int          rdcyc_q[$];
    int          waddr_q[$];
    int          xaddr_q[$];
    int          finish_cyc, finish_cnt, done_cyc, done_cnt, waddr_nz;
    logic [2:0]  st_after_abort;
    logic        busy_after_abort;

    task automatic run_pass(input int n, input int m, input int ncyc, input int hold_until,
                            input int abort_at, input int restart_at);
        fetch_cyc_q.delete(); fa_q.delete(); fb_q.delete(); fwi_q.delete();
        rdcyc_q.delete(); waddr_q.delete(); xaddr_q.delete();
        finish_cyc = -1; finish_cnt = 0; done_cyc = -1; done_cnt = 0; waddr_nz = 0;
        st_after_abort = 3'd7; busy_after_abort = 1'b1;
        @(negedge m_clk);
        bus.cfg_n = 5'(n);
        bus.cfg_m = 5'(m);
        bus.start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge m_clk);
            if (c == 1) begin bus.cfg_n = 5'd7; bus.cfg_m = 5'd9; end
            if (c >= hold_until) bus.start = 1'b0;
            bus.abort = (c == abort_at);
            if (c == restart_at) begin
                bus.start = 1'b1; bus.cfg_n = 5'(n); bus.cfg_m = 5'(m);
            end else if (c == restart_at + 1) begin
                bus.cfg_n = 5'd7; bus.cfg_m = 5'd9;
            end
            if (c == abort_at + 1) begin
                st_after_abort = bus.state_dbg; busy_after_abort = bus.busy;
            end
            if (bus.pe_fetch_enable) begin
                fetch_cyc_q.push_back(c); fa_q.push_back(bus.pe_a);
                fb_q.push_back(bus.pe_b); fwi_q.push_back(int'(bus.pe_weight_index));
            end
            if (bus.pe_finish_enable) begin finish_cyc = c; finish_cnt++; end
            if (bus.done) begin done_cyc = c; done_cnt++; end
            if (bus.x_rd || bus.w_rd) begin
                rdcyc_q.push_back(c); waddr_q.push_back(int'(bus.w_addr));
                xaddr_q.push_back(int'(bus.x_addr));
            end
            if (bus.w_addr != '0) waddr_nz++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        rst = 1'b0;
        repeat (3) @(negedge m_clk);
        outs = {bus.x_addr, bus.w_addr, bus.pe_a, bus.pe_b, bus.pe_weight_index, bus.x_rd,
                bus.w_rd, bus.pe_fetch_enable, bus.pe_finish_enable, bus.busy, bus.done, bus.state_dbg};
        total++;
        if (outs !== 64'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
        rst = 1'b1;
        @(negedge m_clk);
        total++;
        if (bus.busy !== 1'b0 || bus.state_dbg !== 3'd0) begin
            bad++; $display("FAIL reset_release_idle busy=%b state=%0d want 0/0", bus.busy, bus.state_dbg);
        end
    endtask

    task automatic test_pass_2x3(input int hold_until, input string tag);
        int exp_cyc[6] = '{2, 8, 14, 20, 26, 32};
        int exp_a[6]   = '{3, 3, 3, 5, 5, 5};
        int exp_b[6]   = '{1, 2, 3, 4, 5, 6};
        int exp_wi[6]  = '{0, 1, 2, 0, 1, 2};
        run_pass(2, 3, 42, hold_until, -5, -5);
        total++;
        if (fetch_cyc_q.size() !== 6) begin
            bad++; $display("FAIL %s_fetch_count got=%0d want=6", tag, fetch_cyc_q.size());
        end else begin
            for (int p = 0; p < 6; p++) begin
                total++;
                if (fetch_cyc_q[p] !== exp_cyc[p] || fa_q[p] !== 16'(exp_a[p]) ||
                    fb_q[p] !== 16'(exp_b[p]) || fwi_q[p] !== exp_wi[p]) begin
                    bad++;
                    $display("FAIL %s_mac%0d got cyc=%0d a=%0d b=%0d j=%0d want cyc=%0d a=%0d b=%0d j=%0d",
                             tag, p, fetch_cyc_q[p], fa_q[p], fb_q[p], fwi_q[p],
                             exp_cyc[p], exp_a[p], exp_b[p], exp_wi[p]);
                end
            end
        end
        total++;
        if (finish_cyc !== 37 || finish_cnt !== 1) begin
            bad++; $display("FAIL %s_finish got cyc=%0d cnt=%0d want 37/1", tag, finish_cyc, finish_cnt);
        end
        total++;
        if (done_cyc !== 38 || done_cnt !== 1) begin
            bad++; $display("FAIL %s_done got cyc=%0d cnt=%0d want 38/1", tag, done_cyc, done_cnt);
        end
    endtask

    task automatic test_pass_1x1();
        run_pass(1, 1, 12, 1, -5, -5);
        total++;
        if (fetch_cyc_q.size() !== 1 || fetch_cyc_q[0] !== 2 || fa_q[0] !== 16'd3 || fb_q[0] !== 16'd1) begin
            bad++; $display("FAIL one_fetch got n=%0d first_cyc=%0d want 1 at cycle 2",
                            fetch_cyc_q.size(), (fetch_cyc_q.size() > 0) ? fetch_cyc_q[0] : -1);
        end
        total++;
        if (finish_cyc !== 7 || done_cyc !== 8) begin
            bad++; $display("FAIL one_finish_done got fin=%0d done=%0d want 7/8", finish_cyc, done_cyc);
        end
        total++;
        if (waddr_nz !== 0) begin bad++; $display("FAIL one_waddr_zero got nonzero_cycles=%0d want 0", waddr_nz); end
    endtask

    task automatic test_zero_size(input int n, input int m, input string tag);
        run_pass(n, m, 6, 1, -5, -5);
        total++;
        if (done_cyc !== 2 || done_cnt !== 1) begin
            bad++; $display("FAIL %s_done got cyc=%0d cnt=%0d want 2/1", tag, done_cyc, done_cnt);
        end
        total++;
        if (rdcyc_q.size() !== 0 || fetch_cyc_q.size() !== 0 || finish_cnt !== 0) begin
            bad++; $display("FAIL %s_no_pulses got rd=%0d fetch=%0d fin=%0d want 0/0/0", tag,
                            rdcyc_q.size(), fetch_cyc_q.size(), finish_cnt);
        end
    endtask

    task automatic test_pass_16x16();
        int skips;
        run_pass(16, 16, 1545, 1, -5, -5);
        skips = 0;
        for (int p = 0; p < waddr_q.size(); p++) if (waddr_q[p] !== p) skips++;
        total++;
        if (waddr_q.size() !== 256 || skips !== 0) begin
            bad++; $display("FAIL big_waddr_seq got n=%0d wrong=%0d want 256/0", waddr_q.size(), skips);
        end
        total++;
        if (fwi_q.size() !== 256 || fwi_q[255] !== 15 || fa_q[255] !== 16'd33 || fb_q[255] !== 16'd256) begin
            bad++; $display("FAIL big_last_mac got n=%0d want 256 fetches ending j=15 a=33 b=256", fwi_q.size());
        end
        total++;
        if (done_cyc !== 1538 || finish_cyc !== 1537) begin
            bad++; $display("FAIL big_done got done=%0d fin=%0d want 1538/1537", done_cyc, finish_cyc);
        end
    endtask

    task automatic test_abort_restart();
        int exp_w[8] = '{0, 1, 0, 1, 2, 3, 4, 5};
        int wrong;
        run_pass(2, 3, 55, 1, 10, 12);
        total++;
        if (st_after_abort !== 3'd0 || busy_after_abort !== 1'b0) begin
            bad++; $display("FAIL abort_idle got state=%0d busy=%b want 0/0", st_after_abort, busy_after_abort);
        end
        total++;
        if (finish_cnt !== 1 || finish_cyc !== 49 || done_cnt !== 1 || done_cyc !== 50) begin
            bad++; $display("FAIL abort_no_early_fin got fin=%0d@%0d done=%0d@%0d want 1@49 1@50",
                            finish_cnt, finish_cyc, done_cnt, done_cyc);
        end
        wrong = 0;
        if (waddr_q.size() == 8) for (int p = 0; p < 8; p++) if (waddr_q[p] !== exp_w[p]) wrong++;
        total++;
        if (waddr_q.size() !== 8 || wrong !== 0 || rdcyc_q[2] !== 13 || xaddr_q[2] !== 0) begin
            bad++; $display("FAIL restart_fresh got reads=%0d wrong=%0d want 8 reads restarting at k=0 cycle 13",
                            waddr_q.size(), wrong);
        end
        total++;
        if (fetch_cyc_q.size() !== 8 || fetch_cyc_q[2] !== 14 || fa_q[2] !== 16'd3 ||
            fb_q[2] !== 16'd1 || fwi_q[2] !== 0) begin
            bad++; $display("FAIL restart_first_mac got n=%0d want 8 fetches, third=(3,1,0) at 14", fetch_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [63:0] outs;
        int pulses;
        @(negedge m_clk);
        bus.cfg_n = 5'd2; bus.cfg_m = 5'd3; bus.start = 1'b1;
        @(negedge m_clk);
        bus.start = 1'b0;
        repeat (3) @(negedge m_clk);
        total++;
        if (bus.state_dbg !== 3'd3) begin bad++; $display("FAIL pre_reset_wait got state=%0d want 3", bus.state_dbg); end
        #2 rst = 1'b0;
        #1;
        outs = {bus.x_addr, bus.w_addr, bus.pe_a, bus.pe_b, bus.pe_weight_index, bus.x_rd,
                bus.w_rd, bus.pe_fetch_enable, bus.pe_finish_enable, bus.busy, bus.done, bus.state_dbg};
        total++;
        if (outs !== 64'd0) begin bad++; $display("FAIL async_reset_outputs got=%h want=0", outs); end
        @(negedge m_clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge m_clk);
            if (bus.x_rd || bus.w_rd || bus.pe_fetch_enable || bus.pe_finish_enable || bus.done || bus.busy) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL post_reset_quiet got active_cycles=%0d want 0", pulses); end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_n = '0; bus.cfg_m = '0;
        bus.x_data = '0; bus.w_data = '0;
        test_reset();
        test_pass_2x3(1, "pass2x3");
        test_pass_1x1();
        test_zero_size(2, 0, "zero_m");
        test_zero_size(0, 3, "zero_n");
        test_pass_16x16();
        test_abort_restart();
        test_pass_2x3(37, "start_held");
        test_reset_mid_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have parameter I_WIDTH, default 4, the width of the weight_index and loop counters.
REQ-002 The block SHALL have parameter SLOT, default 5, the process-unit cycles per MAC.
REQ-003 m_clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  begin one layer pass; sampled only in IDLE.
REQ-006 abort  in  1  synchronous cancel of a running pass.
REQ-007 cfg_n  in  I_WIDTH+1  input-vector length N, legal 0..2^I_WIDTH.
REQ-008 cfg_m  in  I_WIDTH+1  output count M, legal 0..2^I_WIDTH.
REQ-009 x_addr  out  I_WIDTH  input-vector memory read address.
REQ-010 x_rd  out  1  input-memory read strobe.
REQ-011 x_data  in  16  input-vector data, valid the cycle after x_rd.
REQ-012 w_addr  out  2*I_WIDTH  weight memory read address.
REQ-013 w_rd  out  1  weight-memory read strobe.
REQ-014 w_data  in  16  weight data, valid the cycle after w_rd.
REQ-015 pe_fetch_enable  out  1  one-cycle MAC request to the process unit.
REQ-016 pe_a  out  16  operand a (input element).
REQ-017 pe_b  out  16  operand b (weight).
REQ-018 pe_weight_index  out  I_WIDTH  output column j of the current MAC.
REQ-019 pe_finish_enable  out  1  one-cycle result-out request.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pass-complete pulse.

Function
REQ-022 The FSM SHALL have states IDLE, RD, ISSUE, WAIT, FIN, DONE; all outputs SHALL be registered.
REQ-023 In IDLE with start=1, the block SHALL latch cfg_n/cfg_m, clear i, j and k (weight address), and go to RD; if either latched size is 0, it SHALL go straight to DONE.
REQ-024 Loop order SHALL be i outer (0..N-1), j inner (0..M-1); k SHALL equal i*M+j, kept as a running incrementing counter with no multiplier.
REQ-025 RD (1 cycle) SHALL drive x_addr=i, w_addr=k and x_rd=w_rd=1; the strobes SHALL be 0 in all other states.
REQ-026 ISSUE (1 cycle) SHALL drive pe_a=x_data, pe_b=w_data, pe_weight_index=j and pe_fetch_enable=1.
REQ-027 WAIT SHALL last SLOT-1 cycles with pe_fetch_enable=0, for a MAC period of SLOT+1 cycles, guaranteeing the process unit is back in IDLE before the next fetch.
REQ-028 At the end of WAIT, the block SHALL advance the loop: j++ and k++; if j wraps from M-1 to 0 then i++.
REQ-029 If the wrapped MAC was the last one (i=N-1, j=M-1), the block SHALL go to FIN; otherwise it SHALL go to RD.
REQ-030 FIN (1 cycle) SHALL assert pe_finish_enable=1, then go to DONE.
REQ-031 DONE (1 cycle) SHALL assert done=1, then go to IDLE.
REQ-032 pe_a, pe_b and pe_weight_index SHALL hold their last values outside ISSUE.
REQ-033 start SHALL be ignored when not in IDLE.
REQ-034 Changes to cfg_n/cfg_m after the start edge SHALL have no effect.
REQ-035 abort=1 in any state other than IDLE SHALL force IDLE next cycle with pe_fetch_enable, pe_finish_enable and done all 0, and no FIN/DONE pulse.
REQ-036 If abort and start are both high in IDLE, abort SHALL win and start SHALL be ignored.
REQ-037 The last MAC SHALL be (i=N-1, j=M-1) with k=N*M-1; k SHALL never exceed N*M-1.
REQ-038 Timing: with the start edge as cycle 0, MAC p (0-based) SHALL have RD in cycle p*(SLOT+1)+1 and ISSUE one cycle later; FIN SHALL be in cycle N*M*(SLOT+1)+1 and done in N*M*(SLOT+1)+2.

Reset
REQ-039 While rst=0, the state SHALL be IDLE; i, j, k=0; x_addr, w_addr, pe_a, pe_b, pe_weight_index=0; and x_rd, w_rd, pe_fetch_enable, pe_finish_enable, busy, done=0.
REQ-040 Reset asserted mid-pass SHALL discard the pass immediately; no outputs SHALL pulse after reset release until a new start.

Verification
REQ-041 N=2, M=3, SLOT=5, x=[3,5], W row-major=[1..6] -> the bench SHALL check:
- pe_fetch_enable in cycles 2, 8, 14, 20, 26, 32;
- (pe_a, pe_b, pe_weight_index) = (3,1,0), (3,2,1), (3,3,2), (5,4,0), (5,5,1), (5,6,2);
- pe_finish_enable in cycle 37 and done in cycle 38.
REQ-042 N=1, M=1 -> the bench SHALL check one fetch in cycle 2, pe_finish_enable in cycle 7, done in cycle 8, and w_addr=0 throughout.
REQ-043 cfg_m=0 with start -> the bench SHALL check done in cycle 2, with no x_rd, w_rd, pe_fetch_enable or pe_finish_enable pulse.
REQ-044 N=16, M=16 -> the bench SHALL check w_addr sequences 0..255 without skip, the last fetch has pe_weight_index=15, and done occurs in cycle 1538.
REQ-045 abort in cycle 10 of the 2x3 pass, and start re-pulsed in cycle 12 -> the bench SHALL check IDLE in cycle 11 with no pe_finish_enable and no done, then a fresh pass restarting at i=j=k=0.
REQ-046 rst=0 during a WAIT state, and start held high during a pass -> the bench SHALL check all outputs return to their REQ-039 values asynchronously, and that start during the pass causes no restart and no timing change.
